// File: rtl/snake_pkg.sv
// Shared snake-game definitions: geometry, position type, placement FSM states
// and the LFSR step function used by every randomizer in the game.
package snake_pkg;

    localparam int NUM_LEN = 10;
    localparam int MAX_LEN = 16;
    localparam int IW      = $clog2(MAX_LEN);
    localparam int LW      = IW + 1;

    typedef logic [NUM_LEN-1:0] pos_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Right-shifting Galois step; a nonzero state never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed on reset.
// A zero seed would lock the register at zero, so it is replaced by 1.
module food_lfsr
    import snake_pkg::*;
#(
    parameter logic [15:0] seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    localparam logic [15:0] SEED_NZ = (seed == 16'h0000) ? 16'h0001 : seed;

    logic [15:0] r_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED_NZ;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/food_gen.sv
// Food placer: draws a random cell, scans both snake bodies through the read
// port and linearly probes past occupied cells before publishing the food.
module food_gen
    import snake_pkg::*;
#(
    parameter int          max_len = MAX_LEN,
    parameter int          num_len = NUM_LEN,
    parameter logic [15:0] seed    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       eaten,
    input  logic [$clog2(max_len):0]   snake_len0,
    input  logic [$clog2(max_len):0]   snake_len1,
    output logic                       body_sel,
    output logic [$clog2(max_len)-1:0] body_idx,
    input  logic [num_len-1:0]         body_pos,
    output logic [num_len-1:0]         food,
    output logic                       food_valid,
    output logic                       busy
);

    localparam int IDX_W = $clog2(max_len);
    localparam int LEN_W = IDX_W + 1;

    logic [15:0] w_lfsr;
    logic        w_lfsr_unused;

    food_lfsr #(
        .seed(seed)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_state(w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:num_len];

    state_t              r_state;
    logic [num_len-1:0]  r_cand;
    logic [LEN_W-1:0]    r_len0;
    logic [LEN_W-1:0]    r_len1;
    logic                r_sel;
    logic [IDX_W-1:0]    r_idx;
    logic [num_len-1:0]  r_food;
    logic                r_food_valid;

    state_t              w_state_nxt;
    logic [num_len-1:0]  w_cand_nxt;
    logic [LEN_W-1:0]    w_len0_nxt;
    logic [LEN_W-1:0]    w_len1_nxt;
    logic                w_sel_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [num_len-1:0]  w_food_nxt;
    logic                w_food_valid_nxt;

    logic [LEN_W-1:0]    w_len_sel;
    logic                w_last_seg;
    logic                w_first_sel;
    logic                w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DRAW;
            r_cand       <= '0;
            r_len0       <= '0;
            r_len1       <= '0;
            r_sel        <= 1'b0;
            r_idx        <= '0;
            r_food       <= '0;
            r_food_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_len0       <= w_len0_nxt;
            r_len1       <= w_len1_nxt;
            r_sel        <= w_sel_nxt;
            r_idx        <= w_idx_nxt;
            r_food       <= w_food_nxt;
            r_food_valid <= w_food_valid_nxt;
        end
    end

    // Scan bookkeeping always works from the lengths frozen in DRAW.
    assign w_len_sel   = r_sel ? r_len1 : r_len0;
    assign w_last_seg  = ({1'b0, r_idx} == (w_len_sel - LEN_W'(1)));
    assign w_first_sel = (r_len0 == '0);
    assign w_hit       = (body_pos == r_cand);

    // NOTE: every variable gets a hold default first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_len0_nxt       = r_len0;
        w_len1_nxt       = r_len1;
        w_sel_nxt        = r_sel;
        w_idx_nxt        = r_idx;
        w_food_nxt       = r_food;
        w_food_valid_nxt = r_food_valid;

        case (r_state)
            IDLE: begin
                if (eaten) begin
                    w_food_valid_nxt = 1'b0;
                    w_state_nxt      = DRAW;
                end
            end
            DRAW: begin
                w_cand_nxt = w_lfsr[num_len-1:0];
                w_len0_nxt = snake_len0;
                w_len1_nxt = snake_len1;
                w_sel_nxt  = (snake_len0 == '0);
                w_idx_nxt  = '0;
                if ((snake_len0 == '0) && (snake_len1 == '0)) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_hit) begin
                    // Probe the next cell and rescan every body from the start.
                    w_cand_nxt = r_cand + num_len'(1);
                    w_sel_nxt  = w_first_sel;
                    w_idx_nxt  = '0;
                end else if (!w_last_seg) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end else if (!r_sel && (r_len1 != '0)) begin
                    w_sel_nxt = 1'b1;
                    w_idx_nxt = '0;
                end else begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_food_nxt       = r_cand;
                w_food_valid_nxt = 1'b1;
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt = DRAW;
            end
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        body_sel   = r_sel;
        body_idx   = r_idx;
        food       = r_food;
        food_valid = r_food_valid;
    end

endmodule

// File: tb/tb_food_gen.sv
// Directed bench for food_gen: placement, probing, wrap-around, eaten latency
// and reset in mid-scan, against hand-computed cells and cycle counts.
`timescale 1ns/1ps
module tb_food_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        eaten;
    logic [4:0]  len0;
    logic [4:0]  len1;
    logic [9:0]  body0 [0:15];
    logic [9:0]  body1 [0:15];

    logic        a_sel, b_sel;
    logic [3:0]  a_idx, b_idx;
    logic [9:0]  a_pos, b_pos;
    logic [9:0]  a_food, b_food;
    logic        a_fv, b_fv;
    logic        a_busy, b_busy;

    logic        use_b;
    logic        m_fv;
    logic        m_sel;
    logic [3:0]  m_idx;

    int checks   = 0;
    int failures = 0;
    int n_valid;
    int log_idx [0:63];
    int log_sel [0:63];

    always #5 clk = ~clk;

    assign a_pos = a_sel ? body1[a_idx] : body0[a_idx];
    assign b_pos = b_sel ? body1[b_idx] : body0[b_idx];
    assign m_fv  = use_b ? b_fv  : a_fv;
    assign m_sel = use_b ? b_sel : a_sel;
    assign m_idx = use_b ? b_idx : a_idx;

    food_gen #(.max_len(16), .num_len(10), .seed(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .eaten(eaten),
        .snake_len0(len0), .snake_len1(len1),
        .body_sel(a_sel), .body_idx(a_idx), .body_pos(a_pos),
        .food(a_food), .food_valid(a_fv), .busy(a_busy)
    );

    food_gen #(.max_len(16), .num_len(10), .seed(16'h03FF)) dut_b (
        .clk(clk), .rst(rst), .eaten(eaten),
        .snake_len0(len0), .snake_len1(len1),
        .body_sel(b_sel), .body_idx(b_idx), .body_pos(b_pos),
        .food(b_food), .food_valid(b_fv), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bodies();
        for (int i = 0; i < 16; i++) begin
            body0[i] = 10'h155;
            body1[i] = 10'h2AA;
        end
    endtask

    // Two reset edges, then release: the caller is left in cycle 1 (DRAW).
    task automatic apply_reset();
        rst   = 1'b1;
        eaten = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Logs sel/idx per cycle until food_valid; n_valid is the cycle it rose.
    task automatic run_place(input string name);
        int n;
        n = 1;
        while (!m_fv && n < 200) begin
            log_idx[n] = int'(m_idx);
            log_sel[n] = int'(m_sel);
            tick();
            n++;
        end
        n_valid = n;
        checks++;
        if (!m_fv) begin
            failures++;
            $display("FAIL %s_timeout got food_valid=%b after %0d cycles exp=1", name, m_fv, n);
        end
    endtask

    task automatic test_reset();
        fill_bodies();
        len0  = '0;
        len1  = '0;
        use_b = 1'b0;
        rst   = 1'b1;
        eaten = 1'b0;
        tick();
        tick();
        checks++;
        if (a_food !== 10'h000) begin
            failures++; $display("FAIL reset_food got=%h exp=%h", a_food, 10'h000);
        end
        checks++;
        if (a_fv !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", a_fv);
        end
        checks++;
        if (a_busy !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b exp=1", a_busy);
        end
        checks++;
        if ({a_sel, a_idx} !== 5'd0) begin
            failures++; $display("FAIL reset_body_addr got=%b/%0d exp=0/0", a_sel, a_idx);
        end
        checks++;
        if (dut_a.w_lfsr !== 16'hACE1) begin
            failures++; $display("FAIL reset_lfsr got=%h exp=%h", dut_a.w_lfsr, 16'hACE1);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        // Continues straight from test_reset: now in cycle 1.
        checks++;
        if (a_busy !== 1'b1 || a_fv !== 1'b0) begin
            failures++; $display("FAIL empty_cycle1 got busy=%b valid=%b exp busy=1 valid=0", a_busy, a_fv);
        end
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_fv !== 1'b0) begin
            failures++; $display("FAIL empty_cycle2 got busy=%b valid=%b exp busy=1 valid=0", a_busy, a_fv);
        end
        tick();
        checks++;
        if (a_fv !== 1'b1 || a_busy !== 1'b0) begin
            failures++; $display("FAIL empty_cycle3 got busy=%b valid=%b exp busy=0 valid=1", a_busy, a_fv);
        end
        checks++;
        if (a_food !== 10'h0E1) begin
            failures++; $display("FAIL empty_food got=%h exp=%h", a_food, 10'h0E1);
        end
    endtask

    task automatic test_one_probe();
        int exp_idx [0:6];
        exp_idx = '{0, 1, 2, 0, 1, 2, 3};
        fill_bodies();
        len0 = 5'd4;
        len1 = 5'd0;
        body0[0] = 10'h010;
        body0[1] = 10'h020;
        body0[2] = 10'h0E1;
        body0[3] = 10'h030;
        use_b = 1'b0;
        apply_reset();
        run_place("one_probe");
        checks++;
        if (a_food !== 10'h0E2) begin
            failures++; $display("FAIL one_probe_food got=%h exp=%h", a_food, 10'h0E2);
        end
        checks++;
        if (n_valid != 10) begin
            failures++; $display("FAIL one_probe_latency got=%0d exp=10", n_valid);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_idx[i+2] != exp_idx[i]) begin
                failures++;
                $display("FAIL one_probe_idx[%0d] got=%0d exp=%0d", i, log_idx[i+2], exp_idx[i]);
            end
        end
    endtask

    task automatic test_multi_probe();
        fill_bodies();
        len0 = 5'd2;
        len1 = 5'd1;
        body0[0] = 10'h0E1;
        body0[1] = 10'h0E3;
        body1[0] = 10'h0E2;
        use_b = 1'b0;
        apply_reset();
        run_place("multi_probe");
        checks++;
        if (a_food !== 10'h0E4) begin
            failures++; $display("FAIL multi_probe_food got=%h exp=%h", a_food, 10'h0E4);
        end
        // Scans: 0E1 1 cycle, 0E2 3, 0E3 2, 0E4 3 -> valid in cycle 12.
        checks++;
        if (n_valid != 12) begin
            failures++; $display("FAIL multi_probe_latency got=%0d exp=12", n_valid);
        end
    endtask

    task automatic test_wrap();
        fill_bodies();
        len0 = 5'd0;
        len1 = 5'd1;
        body1[0] = 10'h3FF;
        use_b = 1'b1;
        apply_reset();
        run_place("wrap");
        checks++;
        if (b_food !== 10'h000 || b_fv !== 1'b1) begin
            failures++; $display("FAIL wrap_food got=%h/%b exp=000/1", b_food, b_fv);
        end
        checks++;
        if (n_valid != 5) begin
            failures++; $display("FAIL wrap_latency got=%0d exp=5", n_valid);
        end
        for (int t = 2; t <= 3; t++) begin
            checks++;
            if (log_sel[t] != 1) begin
                failures++; $display("FAIL wrap_sel_cycle%0d got=%0d exp=1", t, log_sel[t]);
            end
        end
        use_b = 1'b0;
    endtask

    task automatic test_eaten_latency();
        fill_bodies();
        len0  = 5'd0;
        len1  = 5'd0;
        use_b = 1'b0;
        apply_reset();
        run_place("latency_setup");
        // Cycle 3, IDLE with food 0E1. DRAW will sample lfsr = step^3(ACE1) = 389C.
        len0 = 5'd3;
        len1 = 5'd2;
        body0[0] = 10'h300; body0[1] = 10'h301; body0[2] = 10'h302;
        body1[0] = 10'h303; body1[1] = 10'h304;
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        checks++;
        if (a_fv !== 1'b0 || a_busy !== 1'b1) begin
            failures++; $display("FAIL latency_after_pulse got valid=%b busy=%b exp valid=0 busy=1", a_fv, a_busy);
        end
        tick();
        tick();
        // Cycle 6: a stray eaten while busy.
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        tick();
        tick();
        tick();
        // Cycle 10: one before completion; old food still shown.
        checks++;
        if (a_fv !== 1'b0 || a_food !== 10'h0E1) begin
            failures++; $display("FAIL latency_cycle7 got valid=%b food=%h exp valid=0 food=0e1", a_fv, a_food);
        end
        tick();
        checks++;
        if (a_fv !== 1'b1 || a_busy !== 1'b0) begin
            failures++; $display("FAIL latency_cycle8 got valid=%b busy=%b exp valid=1 busy=0", a_fv, a_busy);
        end
        checks++;
        if (a_food !== 10'h09C) begin
            failures++; $display("FAIL latency_food got=%h exp=%h", a_food, 10'h09C);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_fv !== 1'b1 || a_busy !== 1'b0 || a_food !== 10'h09C) begin
                failures++;
                $display("FAIL busy_ignore_hold%0d got valid=%b busy=%b food=%h exp 1/0/09c", i, a_fv, a_busy, a_food);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        // Starts in IDLE with food 09C from the previous task.
        len0 = 5'd4;
        len1 = 5'd0;
        body0[0] = 10'h010; body0[1] = 10'h020; body0[2] = 10'h030; body0[3] = 10'h040;
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (a_food !== 10'h000 || a_fv !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL midscan_reset_out got food=%h valid=%b busy=%b exp 000/0/1", a_food, a_fv, a_busy);
        end
        checks++;
        if ({a_sel, a_idx} !== 5'd0) begin
            failures++; $display("FAIL midscan_reset_addr got=%b/%0d exp=0/0", a_sel, a_idx);
        end
        checks++;
        if (dut_a.w_lfsr !== 16'hACE1) begin
            failures++; $display("FAIL midscan_reset_lfsr got=%h exp=%h", dut_a.w_lfsr, 16'hACE1);
        end
        len0 = 5'd0;
        len1 = 5'd0;
        rst  = 1'b0;
        run_place("midscan_rerun");
        checks++;
        if (a_food !== 10'h0E1 || n_valid != 3) begin
            failures++; $display("FAIL midscan_rerun got food=%h cycle=%0d exp food=0e1 cycle=3", a_food, n_valid);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_one_probe();
        test_multi_probe();
        test_wrap();
        test_eaten_latency();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
